// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: bus widths, FSM
// encodings, the NOP word, the default bus timeout and stall-request levels.
package if_fetch_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;

  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;

  // Maximum number of WAIT cycles without an ack before the fetch is aborted.
  localparam int TIMEOUT_DEFAULT = 255;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_fetch.sv
// Instruction fetch stage: issues one bus request per fetch, waits for the
// ack (with timeout), and holds the fetched word for IF/ID until consumed.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INST_ADDR_W-1:0] pc_i,
  input  logic                   ce_i,
  input  logic [5:0]             stall,
  input  logic                   flush_i,
  output logic                   mem_req_o,
  output logic [INST_ADDR_W-1:0] mem_addr_o,
  input  logic                   mem_ack_i,
  input  logic [INST_W-1:0]      mem_rdata_i,
  output logic [INST_ADDR_W-1:0] if_pc_o,
  output logic [INST_W-1:0]      if_inst_o,
  output logic                   if_valid_o,
  output logic                   stallreq_o,
  output logic                   fetch_err_o
);

  // Counter value seen in the last WAIT cycle before the fetch is abandoned.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  // Wait counter step; saturates so a stuck counter can never wrap to zero.
  function automatic logic [7:0] cnt_step(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  fetch_state_e state, state_nxt;

  logic                   drop;
  logic [7:0]             cnt;
  logic [INST_ADDR_W-1:0] req_addr;
  logic [INST_ADDR_W-1:0] buf_pc;
  logic [INST_W-1:0]      buf_inst;

  logic                   issue;
  logic                   capture;
  logic                   wait_done;
  logic                   timeout;
  logic                   cnt_inc;
  logic                   drop_set;
  logic                   req_c;
  logic [INST_ADDR_W-1:0] addr_c;
  logic                   hold_vld;

  // Only the PC-hold bit of the stall vector concerns this stage.
  logic stall_unused;
  assign stall_unused = ^stall[5:1];

  // Next-state decode and per-state bus request/address selection.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    capture   = 1'b0;
    wait_done = 1'b0;
    timeout   = 1'b0;
    cnt_inc   = 1'b0;
    drop_set  = 1'b0;
    req_c     = 1'b0;
    addr_c    = req_addr;
    case (state)
      S_IDLE: begin
        issue  = ce_i & ~flush_i;
        req_c  = issue;
        addr_c = pc_i;
        if (issue) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        req_c = 1'b1;
        if (mem_ack_i) begin
          wait_done = 1'b1;
          // A flush arriving together with the ack discards the word as well.
          if (drop || flush_i) begin
            state_nxt = S_IDLE;
          end else begin
            capture   = 1'b1;
            state_nxt = S_HOLD;
          end
        end else if (cnt == TMO_LAST) begin
          wait_done = 1'b1;
          timeout   = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          cnt_inc  = 1'b1;
          drop_set = flush_i | ~ce_i;
        end
      end
      S_HOLD: begin
        if (!stall[0] || flush_i) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Wait counter and drop flag for the outstanding bus transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= 8'd0;
      drop <= 1'b0;
    end else if (issue) begin
      cnt  <= 8'd0;
      drop <= 1'b0;
    end else if (wait_done) begin
      drop <= 1'b0;
    end else if (cnt_inc) begin
      cnt <= cnt_step(cnt);
      if (drop_set) drop <= 1'b1;
    end
  end

  // Request address and fetched instruction buffers.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_addr <= '0;
      buf_pc   <= '0;
      buf_inst <= NOP_INST;
    end else begin
      if (issue) req_addr <= pc_i;
      if (capture) begin
        buf_pc   <= req_addr;
        buf_inst <= mem_rdata_i;
      end
    end
  end

  // Outputs are forced quiet during the reset cycle so a reset mid-WAIT
  // drops the request immediately.
  always_comb begin
    hold_vld    = (state == S_HOLD) & ~rst;
    mem_req_o   = req_c & ~rst;
    mem_addr_o  = addr_c;
    fetch_err_o = timeout & ~rst;
    if_valid_o  = hold_vld;
    if_inst_o   = hold_vld ? buf_inst : NOP_INST;
    if_pc_o     = hold_vld ? buf_pc : '0;
    stallreq_o  = (ce_i && (state != S_HOLD) && !flush_i && !rst) ? STOP : NO_STOP;
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: stimulus pushes each expected delivery into a
// scoreboard queue; a monitor pops and compares on every new if_valid_o.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        ce_i;
  logic [5:0]  stall;
  logic        flush_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        if_valid_o;
  logic        stallreq_o;
  logic        fetch_err_o;

  int errors = 0;
  int checks = 0;

  logic [63:0] sb[$];   // {pc, inst}
  logic        prev_v = 1'b0;
  int          delivered = 0;

  if_fetch #(.TIMEOUT(255)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_i       (pc_i),
    .ce_i       (ce_i),
    .stall      (stall),
    .flush_i    (flush_i),
    .mem_req_o  (mem_req_o),
    .mem_addr_o (mem_addr_o),
    .mem_ack_i  (mem_ack_i),
    .mem_rdata_i(mem_rdata_i),
    .if_pc_o    (if_pc_o),
    .if_inst_o  (if_inst_o),
    .if_valid_o (if_valid_o),
    .stallreq_o (stallreq_o),
    .fetch_err_o(fetch_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: each fresh delivery must match the oldest expectation.
  always @(negedge clk) begin
    if (if_valid_o && !prev_v) begin
      delivered++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_delivery: got pc 0x%08h inst 0x%08h, expected none",
                 if_pc_o, if_inst_o);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        if ({if_pc_o, if_inst_o} !== e) begin
          errors++;
          $display("FAIL delivery: got pc 0x%08h inst 0x%08h, expected pc 0x%08h inst 0x%08h",
                   if_pc_o, if_inst_o, e[63:32], e[31:0]);
        end
      end
    end
    prev_v = if_valid_o;
  end

  initial begin
    int pulses;
    int first;
    rst = 1'b1; pc_i = 32'h0; ce_i = 1'b0; stall = 6'b0; flush_i = 1'b0;
    mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    repeat (2) tick();

    // Reset cycle: outputs quiet even with ce_i high.
    ce_i = 1'b1;
    #1;
    chk("rst_mem_req",  {31'b0, mem_req_o},   32'd0);
    chk("rst_valid",    {31'b0, if_valid_o},  32'd0);
    chk("rst_stallreq", {31'b0, stallreq_o},  32'd0);
    chk("rst_err",      {31'b0, fetch_err_o}, 32'd0);
    chk("rst_inst",     if_inst_o,            32'h0);

    // Basic fetch, ack one cycle after request.
    rst = 1'b0; pc_i = 32'h0;
    #1;
    chk("t1_req",      {31'b0, mem_req_o},  32'd1);
    chk("t1_addr",     mem_addr_o,          32'h0);
    chk("t1_stallreq", {31'b0, stallreq_o}, 32'd1);
    sb.push_back({32'h0, 32'h3401_0100});
    tick();
    mem_ack_i = 1'b1; mem_rdata_i = 32'h3401_0100;
    #1;
    chk("t1_wait_req", {31'b0, mem_req_o}, 32'd1);
    tick();
    mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    #1;
    chk("t1_hold_valid",    {31'b0, if_valid_o}, 32'd1);
    chk("t1_hold_inst",     if_inst_o,           32'h3401_0100);
    chk("t1_hold_pc",       if_pc_o,             32'h0);
    chk("t1_hold_stallreq", {31'b0, stallreq_o}, 32'd0);
    chk("t1_hold_req",      {31'b0, mem_req_o},  32'd0);
    tick();
    ce_i = 1'b0;
    #1;
    chk("t1_idle_valid", {31'b0, if_valid_o}, 32'd0);
    chk("t1_idle_req",   {31'b0, mem_req_o},  32'd0);

    // Ack delayed 5 cycles; address held stable while pc_i moves.
    ce_i = 1'b1; pc_i = 32'h0000_0100;
    sb.push_back({32'h0000_0100, 32'h1111_1111});
    tick();
    pc_i = 32'h0000_0200;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t2_wait_addr",     mem_addr_o,          32'h0000_0100);
      chk("t2_wait_stallreq", {31'b0, stallreq_o}, 32'd1);
      tick();
    end
    mem_ack_i = 1'b1; mem_rdata_i = 32'h1111_1111;
    #1;
    chk("t2_ack_addr",     mem_addr_o,          32'h0000_0100);
    chk("t2_ack_stallreq", {31'b0, stallreq_o}, 32'd1);
    tick();
    mem_ack_i = 1'b0;

    // Held by stall[0]; a stray ack during HOLD must not disturb the buffer.
    stall = 6'b000011;
    for (int i = 0; i < 3; i++) begin
      mem_ack_i = (i == 1); mem_rdata_i = 32'hBAD0_BAD0;
      #1;
      chk("t3_hold_valid", {31'b0, if_valid_o}, 32'd1);
      chk("t3_hold_inst",  if_inst_o,           32'h1111_1111);
      chk("t3_hold_pc",    if_pc_o,             32'h0000_0100);
      chk("t3_hold_req",   {31'b0, mem_req_o},  32'd0);
      tick();
    end
    mem_ack_i = 1'b0; stall = 6'b0;
    #1;
    chk("t3_release_valid", {31'b0, if_valid_o}, 32'd1);
    tick();
    #1;
    chk("t3_next_req",   {31'b0, mem_req_o},  32'd1);
    chk("t3_next_addr",  mem_addr_o,          32'h0000_0200);
    chk("t3_idle_valid", {31'b0, if_valid_o}, 32'd0);
    chk("t3_idle_inst",  if_inst_o,           32'h0);
    chk("t3_idle_pc",    if_pc_o,             32'h0);

    // Flush in WAIT; the late ack's data must be discarded.
    tick();
    flush_i = 1'b1;
    #1;
    chk("t4_flush_stallreq", {31'b0, stallreq_o}, 32'd0);
    chk("t4_flush_req",      {31'b0, mem_req_o},  32'd1);
    tick();
    flush_i = 1'b0;
    tick();
    mem_ack_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
    tick();
    mem_ack_i = 1'b0; ce_i = 1'b0;
    #1;
    chk("t4_idle_valid", {31'b0, if_valid_o}, 32'd0);
    chk("t4_idle_req",   {31'b0, mem_req_o},  32'd0);
    ce_i = 1'b1; pc_i = 32'h0000_0300;
    #1;
    chk("t4_idle_newreq", {31'b0, mem_req_o}, 32'd1);
    chk("t4_idle_addr",   mem_addr_o,         32'h0000_0300);

    // Timeout: no ack at all; one error pulse in the 255th WAIT cycle.
    tick();
    pulses = 0; first = -1;
    for (int n = 0; n < 260; n++) begin
      #1;
      if (fetch_err_o) begin
        pulses++;
        if (first < 0) first = n;
      end
      if (n == 255) begin
        chk("t5_retry_req",  {31'b0, mem_req_o}, 32'd1);
        chk("t5_retry_addr", mem_addr_o,         32'h0000_0300);
      end
      tick();
    end
    chk("t5_err_pulses", pulses, 32'd1);
    chk("t5_err_cycle",  first,  32'd254);

    // Reset mid-WAIT, then a late ack arrives in IDLE.
    rst = 1'b1;
    #1;
    chk("t6_rst_req",      {31'b0, mem_req_o},   32'd0);
    chk("t6_rst_stallreq", {31'b0, stallreq_o},  32'd0);
    chk("t6_rst_err",      {31'b0, fetch_err_o}, 32'd0);
    tick();
    rst = 1'b0; ce_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'hCAFE_F00D;
    #1;
    chk("t6_late_req", {31'b0, mem_req_o}, 32'd0);
    tick();
    mem_ack_i = 1'b0;
    #1;
    chk("t6_late_valid", {31'b0, if_valid_o}, 32'd0);
    ce_i = 1'b1; pc_i = 32'h0000_0400;
    #1;
    chk("t6_resume_req",  {31'b0, mem_req_o}, 32'd1);
    chk("t6_resume_addr", mem_addr_o,         32'h0000_0400);
    sb.push_back({32'h0000_0400, 32'h55AA_55AA});
    tick();
    mem_ack_i = 1'b1; mem_rdata_i = 32'h55AA_55AA;
    tick();
    mem_ack_i = 1'b0;
    #1;
    chk("t6_hold_inst", if_inst_o, 32'h55AA_55AA);
    tick();
    ce_i = 1'b0;
    repeat (3) tick();

    chk("sb_empty",  sb.size(), 32'd0);
    chk("delivered", delivered, 32'd3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
